// File: rtl/bus_arbiter.sv
// Round-robin arbiter merging N_MASTERS core bus-master ports onto one shared slave port.
// Define BUS_ARB_TIMEOUT_EN to add a TIMEOUT watchdog that self-acks a stuck transfer and flags o_err.
module bus_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int XLEN      = 32
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 255
`endif
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_MASTERS-1:0]      i_m_bus_en,
    input  logic [N_MASTERS-1:0]      i_m_wr_en,
    input  logic [N_MASTERS*XLEN-1:0] i_m_addr,
    input  logic [N_MASTERS*XLEN-1:0] i_m_wr_data,
    input  logic [N_MASTERS*4-1:0]    i_m_byte_en,
    output logic [N_MASTERS-1:0]      o_m_ack,
    output logic [XLEN-1:0]           o_m_rd_data,
    output logic                      o_s_bus_en,
    output logic                      o_s_wr_en,
    output logic [XLEN-1:0]           o_s_addr,
    output logic [XLEN-1:0]           o_s_wr_data,
    output logic [3:0]                o_s_byte_en,
    input  logic                      i_s_ack,
    input  logic [XLEN-1:0]           i_s_rd_data,
    output logic [N_MASTERS-1:0]      o_grant
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    output logic                      o_err
`endif
);

    localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    // state | meaning
    // IDLE  | no grant; pick next requester after last served
    // BUSY  | grant held on g until slave ack, abort or timeout
    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state;
    logic [GW-1:0]         g;
    logic [GW-1:0]         last;
    logic [GW-1:0]         next_g;
    logic [N_MASTERS-1:0]  grant;
    logic                  busy;
    logic                  any_req;
    logic                  timeout;

    assign busy    = (state == BUSY);
    assign any_req = |i_m_bus_en;

    // Descending scan so the requester closest after last wins.
    always_comb begin
        next_g = last;
        for (int i = N_MASTERS; i >= 1; i--) begin
            if (i_m_bus_en[(int'(last) + i) % N_MASTERS]) begin
                next_g = GW'((int'(last) + i) % N_MASTERS);
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    assign timeout = busy && !i_s_ack && (tmo_cnt == TW'(TIMEOUT));
    assign o_err   = timeout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt <= '0;
        end else if (!busy) begin
            tmo_cnt <= '0;
        end else if (!i_s_ack && !timeout) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            g     <= '0;
            last  <= GW'(N_MASTERS - 1);
            grant <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        g     <= next_g;
                        grant <= N_MASTERS'(1) << next_g;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (i_s_ack || timeout) begin
                        last  <= g;
                        grant <= '0;
                        state <= IDLE;
                    end else if (!i_m_bus_en[g]) begin
                        grant <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Slave side is a live mux of the granted master so the request appears one cycle after arbitration.
    assign o_s_bus_en  = busy && i_m_bus_en[g] && !timeout;
    assign o_s_wr_en   = busy && i_m_wr_en[g];
    assign o_s_addr    = busy ? i_m_addr[g*XLEN +: XLEN]    : '0;
    assign o_s_wr_data = busy ? i_m_wr_data[g*XLEN +: XLEN] : '0;
    assign o_s_byte_en = busy ? i_m_byte_en[g*4 +: 4]       : 4'b0000;

    assign o_m_ack     = (busy && (i_s_ack || timeout)) ? grant : '0;
    assign o_m_rd_data = timeout ? '0 : i_s_rd_data;
    assign o_grant     = grant;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: bench-side masters and slave, round-robin reference model, negedge monitor.
module tb_bus_arbiter;
    localparam int NM = 3;
    localparam int XL = 32;

    typedef struct packed {
        logic [7:0]  m;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } txn_t;

    logic               i_clk;
    logic               i_rst_n;
    logic [NM-1:0]      i_m_bus_en;
    logic [NM-1:0]      i_m_wr_en;
    logic [NM*XL-1:0]   i_m_addr;
    logic [NM*XL-1:0]   i_m_wr_data;
    logic [NM*4-1:0]    i_m_byte_en;
    logic [NM-1:0]      o_m_ack;
    logic [XL-1:0]      o_m_rd_data;
    logic               o_s_bus_en;
    logic               o_s_wr_en;
    logic [XL-1:0]      o_s_addr;
    logic [XL-1:0]      o_s_wr_data;
    logic [3:0]         o_s_byte_en;
    logic               i_s_ack;
    logic [XL-1:0]      i_s_rd_data;
    logic [NM-1:0]      o_grant;

    bus_arbiter #(.N_MASTERS(NM), .XLEN(XL)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_m_bus_en(i_m_bus_en), .i_m_wr_en(i_m_wr_en), .i_m_addr(i_m_addr),
        .i_m_wr_data(i_m_wr_data), .i_m_byte_en(i_m_byte_en),
        .o_m_ack(o_m_ack), .o_m_rd_data(o_m_rd_data),
        .o_s_bus_en(o_s_bus_en), .o_s_wr_en(o_s_wr_en), .o_s_addr(o_s_addr),
        .o_s_wr_data(o_s_wr_data), .o_s_byte_en(o_s_byte_en),
        .i_s_ack(i_s_ack), .i_s_rd_data(i_s_rd_data), .o_grant(o_grant)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // master-side state
    txn_t pend[$];
    txn_t cur[NM];
    bit   active[NM];
    bit   abort_req[NM];

    // slave-side state
    int          s_cnt = 0;
    int          s_lat = 1;
    bit          rand_lat = 0;
    bit          force_ack = 0;
    logic [31:0] s_data_next = 32'h0;
    logic [31:0] s_data_drv = 32'h0;

    // reference model
    bit   mbusy = 0;
    int   mg = 0;
    int   mlast = NM - 1;
    txn_t expq[$];

    // monitor observations
    int          served[$];
    logic [31:0] last_rd, last_s_addr, last_s_wdata;
    logic        last_s_wr;
    logic [3:0]  last_s_be;
    bit          prev_en = 0;
    int          gap_cnt = 0;
    int          last_gap = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic issue(int m, logic wr, logic [31:0] a, logic [31:0] d, logic [3:0] be);
        txn_t t;
        t.m = 8'(m); t.wr = wr; t.addr = a; t.data = d; t.be = be;
        pend.push_back(t);
    endtask

    // Arbitration rule: when idle, the first requester after the last served one (cyclically) wins.
    task automatic model_step();
        bit found;
        if (!mbusy) begin
            found = 0;
            for (int i = 1; i <= NM; i++) begin
                if (!found && i_m_bus_en[(mlast + i) % NM]) begin
                    mg = (mlast + i) % NM;
                    found = 1;
                end
            end
            if (found) begin
                mbusy = 1;
                expq.push_back(cur[mg]);
            end
        end else if (i_s_ack) begin
            mbusy = 0;
            mlast = mg;
        end else if (!i_m_bus_en[mg]) begin
            mbusy = 0;
            expq.delete();
        end
    endtask

    task automatic cycle();
        logic [NM-1:0] ack_n;
        logic          s_en_n;
        bit            took;
        @(negedge i_clk);
        ack_n  = o_m_ack;
        s_en_n = o_s_bus_en;
        @(posedge i_clk);
        if (i_rst_n) model_step();
        #1;
        for (int k = 0; k < NM; k++) begin
            if (active[k]) begin
                if (ack_n[k] || abort_req[k]) begin
                    active[k]     = 0;
                    abort_req[k]  = 0;
                    i_m_bus_en[k] = 1'b0;
                end
            end else begin
                took = 0;
                for (int j = 0; j < pend.size() && !took; j++) begin
                    if (int'(pend[j].m) == k) begin
                        cur[k] = pend[j];
                        pend.delete(j);
                        took = 1;
                    end
                end
                if (took) begin
                    active[k]                = 1;
                    i_m_bus_en[k]            = 1'b1;
                    i_m_wr_en[k]             = cur[k].wr;
                    i_m_addr[k*XL +: XL]     = cur[k].addr;
                    i_m_wr_data[k*XL +: XL]  = cur[k].data;
                    i_m_byte_en[k*4 +: 4]    = cur[k].be;
                end
            end
        end
        if (i_s_ack) begin
            i_s_ack     = 1'b0;
            i_s_rd_data = $urandom;
            s_cnt       = 0;
        end else if (force_ack) begin
            force_ack   = 0;
            i_s_ack     = 1'b1;
            i_s_rd_data = $urandom;
        end else if (s_en_n) begin
            s_cnt++;
            if (s_cnt >= s_lat) begin
                s_data_drv  = s_data_next;
                i_s_ack     = 1'b1;
                i_s_rd_data = s_data_drv;
                s_data_next = $urandom;
                s_cnt       = 0;
                if (rand_lat) s_lat = $urandom_range(1, 4);
            end
        end else begin
            s_cnt       = 0;
            i_s_rd_data = $urandom;
        end
    endtask

    task automatic wait_idle(int budget);
        int n;
        bit pending;
        n = 0;
        pending = 1;
        while (pending && n < budget) begin
            cycle();
            n++;
            pending = mbusy || (pend.size() > 0);
            for (int k = 0; k < NM; k++) if (active[k]) pending = 1;
        end
        chk("wait_idle_within_budget", 64'(pending), 64'(0));
    endtask

    // Called right after cycle(), i.e. just past a rising edge, so reset lands between edges.
    task automatic do_reset();
        #2 i_rst_n = 1'b0;
        mbusy = 0; mlast = NM - 1; expq.delete(); pend.delete();
        for (int k = 0; k < NM; k++) begin active[k] = 0; abort_req[k] = 0; end
        i_m_bus_en = '0; i_s_ack = 1'b0; s_cnt = 0; force_ack = 0;
        #1;
        chk("rst_async_s_bus_en", 64'(o_s_bus_en), 64'(0));
        chk("rst_async_grant", 64'(o_grant), 64'(0));
        chk("rst_async_m_ack", 64'(o_m_ack), 64'(0));
        cycle();
        cycle();
        #2 i_rst_n = 1'b1;
    endtask

    always @(negedge i_clk) begin
        logic [NM-1:0] eg, ea;
        txn_t t;
        if (i_rst_n) begin
            eg = '0;
            ea = '0;
            if (mbusy) eg[mg] = 1'b1;
            if (mbusy && i_s_ack) ea[mg] = 1'b1;
            chk("s_bus_en", 64'(o_s_bus_en), 64'(mbusy && i_m_bus_en[mg]));
            chk("grant", 64'(o_grant), 64'(eg));
            chk("m_ack", 64'(o_m_ack), 64'(ea));
            if (o_s_bus_en && expq.size() > 0) begin
                chk("s_addr", 64'(o_s_addr), 64'(expq[0].addr));
                chk("s_wr_en", 64'(o_s_wr_en), 64'(expq[0].wr));
                chk("s_wr_data", 64'(o_s_wr_data), 64'(expq[0].data));
                chk("s_byte_en", 64'(o_s_byte_en), 64'(expq[0].be));
            end
            if (ea != '0 && expq.size() > 0) begin
                t = expq.pop_front();
                chk("m_rd_data", 64'(o_m_rd_data), 64'(s_data_drv));
                served.push_back(int'(t.m));
                last_rd      = o_m_rd_data;
                last_s_addr  = o_s_addr;
                last_s_wdata = o_s_wr_data;
                last_s_wr    = o_s_wr_en;
                last_s_be    = o_s_byte_en;
            end
            if (o_s_bus_en) begin
                if (!prev_en) last_gap = gap_cnt;
                gap_cnt = 0;
            end else begin
                gap_cnt++;
            end
            prev_en = o_s_bus_en;
        end
    end

    initial begin
        int n_rand;
        i_rst_n = 1'b0;
        i_m_bus_en = '0; i_m_wr_en = '0; i_m_addr = '0; i_m_wr_data = '0; i_m_byte_en = '0;
        i_s_ack = 1'b0; i_s_rd_data = '0;
        for (int k = 0; k < NM; k++) begin active[k] = 0; abort_req[k] = 0; end
        #1;
        chk("reset_s_bus_en", 64'(o_s_bus_en), 64'(0));
        chk("reset_grant", 64'(o_grant), 64'(0));
        chk("reset_m_ack", 64'(o_m_ack), 64'(0));
        chk("reset_s_fields", {o_s_addr, o_s_wr_data}, 64'(0));
        chk("reset_s_wr_be", 64'({o_s_wr_en, o_s_byte_en}), 64'(0));
        repeat (3) @(posedge i_clk);
        #3 i_rst_n = 1'b1;

        // single master read
        served.delete();
        s_lat = 3; s_data_next = 32'hDEAD_BEEF;
        issue(0, 1'b0, 32'h100, 32'h0, 4'hF);
        wait_idle(40);
        chk("t1_served_count", 64'(served.size()), 64'(1));
        if (served.size() > 0) chk("t1_master", 64'(served[0]), 64'(0));
        chk("t1_addr", 64'(last_s_addr), 64'h100);
        chk("t1_rd_data", 64'(last_rd), 64'hDEAD_BEEF);
        chk("t1_grant_idle", 64'(o_grant), 64'(0));

        // simultaneous requests right out of reset
        do_reset();
        served.delete();
        s_lat = 2;
        issue(1, 1'b0, 32'h200, 32'h0, 4'hF);
        issue(0, 1'b0, 32'h300, 32'h0, 4'hF);
        wait_idle(60);
        chk("t2_served_count", 64'(served.size()), 64'(2));
        if (served.size() == 2) begin
            chk("t2_first", 64'(served[0]), 64'(0));
            chk("t2_second", 64'(served[1]), 64'(1));
        end
        chk("t2_idle_gap", 64'(last_gap), 64'(1));

        // continuous contention between masters 0 and 1
        served.delete();
        s_lat = 1;
        for (int i = 0; i < 3; i++) begin
            issue(0, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 4'hF);
            issue(1, 1'b1, 32'h2000 + 32'(i * 4), $urandom, 4'hF);
        end
        wait_idle(120);
        chk("t3_served_count", 64'(served.size()), 64'(6));
        for (int i = 0; i < served.size() && i < 6; i++) chk("t3_rr_order", 64'(served[i]), 64'(i % 2));

        // write passthrough from master 1
        served.delete();
        s_lat = 2;
        issue(1, 1'b1, 32'h2004, 32'h1234_5678, 4'b0011);
        wait_idle(40);
        chk("t4_served_count", 64'(served.size()), 64'(1));
        if (served.size() > 0) chk("t4_master", 64'(served[0]), 64'(1));
        chk("t4_wr_en", 64'(last_s_wr), 64'(1));
        chk("t4_addr", 64'(last_s_addr), 64'h2004);
        chk("t4_wr_data", 64'(last_s_wdata), 64'h1234_5678);
        chk("t4_byte_en", 64'(last_s_be), 64'b0011);

        // abort by master 0 must leave the round-robin pointer alone
        served.delete();
        s_lat = 20;
        issue(0, 1'b0, 32'h400, 32'h0, 4'hF);
        repeat (3) cycle();
        abort_req[0] = 1;
        repeat (3) cycle();
        chk("t5_abort_idle", 64'(o_grant), 64'(0));
        chk("t5_abort_no_ack", 64'(served.size()), 64'(0));
        s_lat = 1;
        issue(1, 1'b0, 32'h500, 32'h0, 4'hF);
        issue(0, 1'b0, 32'h600, 32'h0, 4'hF);
        wait_idle(60);
        chk("t5_served_count", 64'(served.size()), 64'(2));
        if (served.size() == 2) chk("t5_first", 64'(served[0]), 64'(0));

        // slave ack while idle is ignored
        force_ack = 1;
        cycle();
        #2;
        chk("t6_idle_ack_ignored", 64'(o_m_ack), 64'(0));
        cycle();

        // async reset mid-transfer restores master-0 priority
        served.delete();
        s_lat = 1;
        issue(0, 1'b0, 32'h700, 32'h0, 4'hF);
        wait_idle(40);
        s_lat = 20;
        issue(1, 1'b0, 32'h800, 32'h0, 4'hF);
        repeat (3) cycle();
        chk("t7_busy_before_reset", 64'(o_s_bus_en), 64'(1));
        do_reset();
        served.delete();
        s_lat = 1;
        issue(1, 1'b0, 32'h900, 32'h0, 4'hF);
        issue(0, 1'b0, 32'hA00, 32'h0, 4'hF);
        wait_idle(60);
        chk("t7_served_count", 64'(served.size()), 64'(2));
        if (served.size() == 2) begin
            chk("t7_first", 64'(served[0]), 64'(0));
            chk("t7_second", 64'(served[1]), 64'(1));
        end

        // randomized traffic from all masters
        served.delete();
        rand_lat = 1;
        s_lat = $urandom_range(1, 4);
        n_rand = 0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NM; k++) begin
                bit queued;
                queued = 0;
                foreach (pend[j]) if (int'(pend[j].m) == k) queued = 1;
                if (!active[k] && !queued && $urandom_range(0, 2) == 0) begin
                    issue(k, 1'($urandom), $urandom, $urandom, 4'($urandom));
                    n_rand++;
                end
            end
            cycle();
        end
        wait_idle(200);
        chk("rand_all_served", 64'(served.size()), 64'(n_rand));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
